fifo2axis_packer: RTL and testbench

Upstream feeder for `axis2fifo`. Pops 32-bit results from a first-word-fall-through-free (1-cycle read latency) result FIFO and forms fixed-length AXI-Stream packets on `result_data`/`valid_result`/`last`, honouring `ready_for_results` backpressure. Packets are exactly `PACKET_LEN` words; an optional flush pads a partial packet with `PAD_WORD` so the downstream always receives complete packets.

---
 rtl/fifo2axis_packer.sv | 154 +++++++++++++++
 tb/tb_fifo2axis_packer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo2axis_packer.sv
// rtl/fifo2axis_packer.sv - packs result-FIFO words into fixed-length AXI-Stream packets
// Flush/pad completion of partial packets is built when FIFO2AXIS_FLUSH_EN is defined.
module fifo2axis_packer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    PACKET_LEN = 4,
  parameter logic [DATA_WIDTH-1:0] PAD_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] result_data,
  output logic                  valid_result,
  output logic                  last,
  input  logic                  ready_for_results,
  input  logic                  flush,
  output logic                  busy,
  output logic [15:0]           pkt_sent
);
  localparam int             IW       = (PACKET_LEN > 2) ? $clog2(PACKET_LEN) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(PACKET_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM
`ifdef FIFO2AXIS_FLUSH_EN
    , ST_PAD
`endif
  } state_t;

  state_t                r_state, w_state_n;
  logic                  r_out_valid, r_out_last, r_skid_valid, r_inflight;
  logic [DATA_WIDTH-1:0] r_out_data, r_skid_data;
  logic [IW-1:0]         r_widx;
  logic [15:0]           r_pkt_sent;

  logic                  w_xfer, w_out_free, w_rd, w_drained;
  logic                  w_load, w_skid_load, w_in_pad, w_pad_load, w_flush_pend;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [1:0]            w_fill;

`ifdef FIFO2AXIS_FLUSH_EN
  logic r_flush_pend;
  assign w_flush_pend = r_flush_pend;
  assign w_in_pad     = (r_state == ST_PAD);
  assign w_pad_load   = w_in_pad && (r_widx != '0);
`else
  logic [DATA_WIDTH:0] w_unused;
  assign w_unused     = {flush, PAD_WORD};
  assign w_flush_pend = 1'b0;
  assign w_in_pad     = 1'b0;
  assign w_pad_load   = 1'b0;
`endif

  // Fill counts the slot freed by this cycle's transfer so a read can overlap it.
  assign w_xfer     = r_out_valid && ready_for_results;
  assign w_out_free = !r_out_valid || w_xfer;
  assign w_fill     = 2'(r_out_valid) + 2'(r_skid_valid) + 2'(r_inflight) - 2'(w_xfer);
  assign w_rd       = rst && !fifo_empty && (w_fill < 2'd2) && !w_flush_pend && !w_in_pad;
  assign w_drained  = !r_skid_valid && !r_inflight;

  always_comb begin
    w_load      = 1'b0;
    w_skid_load = 1'b0;
    w_load_data = r_out_data;
    if (w_out_free) begin
      if (r_skid_valid) begin
        w_load      = 1'b1;
        w_load_data = r_skid_data;
        w_skid_load = r_inflight;
      end else if (r_inflight) begin
        w_load      = 1'b1;
        w_load_data = fifo_dout;
      end else if (w_pad_load) begin
        w_load      = 1'b1;
        w_load_data = PAD_WORD;
      end
    end else begin
      w_skid_load = r_inflight;
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE: if (w_rd) w_state_n = ST_STREAM;
      ST_STREAM: begin
        if (w_xfer && r_out_last && w_drained && fifo_empty) w_state_n = ST_IDLE;
`ifdef FIFO2AXIS_FLUSH_EN
        else if (w_flush_pend && w_drained && (r_widx != '0)) w_state_n = ST_PAD;
`endif
      end
`ifdef FIFO2AXIS_FLUSH_EN
      ST_PAD: if ((r_widx == '0) && w_xfer) w_state_n = ST_IDLE;
`endif
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_inflight   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_widx       <= '0;
      r_pkt_sent   <= '0;
    end else begin
      r_state    <= w_state_n;
      r_inflight <= w_rd;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_load_data;
        r_out_last  <= (r_widx == LAST_IDX);
        r_widx      <= (r_widx == LAST_IDX) ? '0 : r_widx + IW'(1);
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      if (w_skid_load) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= fifo_dout;
      end else if (w_out_free && r_skid_valid) begin
        r_skid_valid <= 1'b0;
      end
      if (w_xfer && r_out_last) r_pkt_sent <= r_pkt_sent + 16'd1;
    end
  end

`ifdef FIFO2AXIS_FLUSH_EN
  // Pending ends after the last pad word leaves, or at once if no packet was open.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flush_pend <= 1'b0;
    end else if (r_flush_pend) begin
      if ((w_in_pad && (r_widx == '0) && w_xfer) || (!w_in_pad && w_drained && (r_widx == '0)))
        r_flush_pend <= 1'b0;
    end else if (flush && !w_in_pad) begin
      r_flush_pend <= 1'b1;
    end
  end
`endif

  assign fifo_rd_en   = w_rd;
  assign result_data  = r_out_data;
  assign valid_result = r_out_valid;
  assign last         = r_out_last;
  assign pkt_sent     = r_pkt_sent;
  assign busy         = r_out_valid || r_skid_valid || r_inflight || (r_widx != '0) || w_in_pad;
endmodule

// File: tb/tb_fifo2axis_packer.sv
// tb/tb_fifo2axis_packer.sv - self-checking bench for fifo2axis_packer
module tb_fifo2axis_packer;
  localparam int          PL   = 4;
  localparam logic [31:0] PADW = 32'h0;
`ifdef FIFO2AXIS_FLUSH_EN
  localparam bit FL_ON = 1'b1;
`else
  localparam bit FL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] result_data;
  logic        valid_result;
  logic        last;
  logic        ready_for_results;
  logic        flush;
  logic        busy;
  logic [15:0] pkt_sent;

  always #5 clk = ~clk;

  fifo2axis_packer #(.DATA_WIDTH(32), .PACKET_LEN(PL), .PAD_WORD(PADW)) dut (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .result_data(result_data), .valid_result(valid_result),
    .last(last), .ready_for_results(ready_for_results), .flush(flush),
    .busy(busy), .pkt_sent(pkt_sent)
  );

  typedef struct {
    int          n;
    logic [31:0] base;
    bit          rnd;
    int          mode;
    bit          fl;
    int          exp_n;
    int          exp_pk;
    logic        exp_busy;
    bit          lat;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] got_d[$];
  logic        got_l[$];
  logic [31:0] exp_d[$];
  logic        exp_l[$];
  int rdy_mode, cyc, reads, xfers, outst_viol, stall_viol, first_rd, first_val, bubbles, exp_total;
  logic busy_seen, p_stall, p_last;
  logic [31:0] p_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    got_d.delete(); got_l.delete();
    cyc = 0; reads = 0; xfers = 0; outst_viol = 0; stall_viol = 0;
    first_rd = -1; first_val = -1; bubbles = 0; busy_seen = 1'b0; p_stall = 1'b0;
    p_data = '0; p_last = 1'b0;
  endtask

  // Samples the cycle at negedge, then applies FIFO pop and new inputs 1 ns after posedge.
  task automatic step();
    logic s_rd, s_x;
    @(negedge clk);
    cyc++;
    s_rd = fifo_rd_en;
    s_x  = valid_result && ready_for_results;
    if (busy) busy_seen = 1'b1;
    if (p_stall && !(valid_result && result_data == p_data && last == p_last)) stall_viol++;
    if ((reads + int'(s_rd)) - (xfers + int'(s_x)) > 2) outst_viol++;
    if (s_rd) begin
      reads++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (valid_result && first_val < 0) first_val = cyc;
    if (!valid_result && first_val >= 0 && got_d.size() < exp_total) bubbles++;
    if (s_x) begin
      xfers++;
      got_d.push_back(result_data);
      got_l.push_back(last);
    end
    p_stall = valid_result && !ready_for_results;
    p_data  = result_data;
    p_last  = last;
    @(posedge clk);
    #1;
    if (s_rd && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
    flush = 1'b0;
    ready_for_results = (rdy_mode == 0) ? 1'b1 :
                        (rdy_mode == 1) ? !ready_for_results : 1'($urandom_range(0, 1));
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic do_reset(input int mode);
    rdy_mode = mode;
    rst = 1'b0;
    flush = 1'b0;
    ready_for_results = 1'b1;
    fifo_q.delete();
    fifo_empty = 1'b1;
    fifo_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_obs();
  endtask

  vec_t tbl[7];

  initial begin
    vec_t        t;
    logic [31:0] w;
    int          npk;

    tbl[0] = '{8,  32'h10, 1'b0, 0, 1'b0, 8,                2,                1'b0,        1'b1};
    tbl[1] = '{8,  32'h10, 1'b0, 1, 1'b0, 8,                2,                1'b0,        1'b0};
    tbl[2] = '{3,  32'hA1, 1'b0, 0, 1'b1, FL_ON ? 4 : 3,    FL_ON ? 1 : 0,    !FL_ON,      1'b0};
    tbl[3] = '{0,  32'h00, 1'b0, 0, 1'b1, 0,                0,                1'b0,        1'b0};
    tbl[4] = '{12, 32'h00, 1'b1, 2, 1'b0, 12,               3,                1'b0,        1'b0};
    tbl[5] = '{6,  32'h00, 1'b1, 2, 1'b1, FL_ON ? 8 : 6,    FL_ON ? 2 : 1,    !FL_ON,      1'b0};
    tbl[6] = '{5,  32'h50, 1'b0, 0, 1'b0, 5,                1,                1'b1,        1'b0};

    do_reset(0);
    chk("reset_valid", valid_result, 0);
    chk("reset_last", last, 0);
    chk("reset_data", result_data, 0);
    chk("reset_rd_en", fifo_rd_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pkt_sent", pkt_sent, 0);

    for (int i = 0; i < 7; i++) begin
      t = tbl[i];
      do_reset(t.mode);
      exp_total = t.n;
      exp_d.delete(); exp_l.delete();
      for (int k = 0; k < t.n; k++) begin
        w = t.rnd ? $urandom() : t.base + k;
        push(w);
        exp_d.push_back(w);
        exp_l.push_back((k % PL) == PL - 1);
      end
      if (t.fl && FL_ON && (t.n % PL) != 0)
        for (int k = t.n % PL; k < PL; k++) begin
          exp_d.push_back(PADW);
          exp_l.push_back(k == PL - 1);
        end
      for (int g = 0; g < 200 && fifo_q.size() > 0; g++) step();
      chk($sformatf("v%0d_drain", i), fifo_q.size(), 0);
      repeat (4) step();
      if (t.fl) begin
        flush = 1'b1;
        step();
      end
      repeat (60) step();

      chk($sformatf("v%0d_count", i), got_d.size(), t.exp_n);
      chk($sformatf("v%0d_count_model", i), got_d.size(), exp_d.size());
      npk = 0;
      for (int j = 0; j < exp_d.size(); j++) begin
        if (exp_l[j]) npk++;
        if (j < got_d.size()) begin
          chk($sformatf("v%0d_data%0d", i, j), got_d[j], exp_d[j]);
          chk($sformatf("v%0d_last%0d", i, j), got_l[j], exp_l[j]);
        end
      end
      chk($sformatf("v%0d_pkt_sent", i), pkt_sent, t.exp_pk);
      chk($sformatf("v%0d_pkt_model", i), pkt_sent, npk);
      chk($sformatf("v%0d_busy", i), busy, t.exp_busy);
      chk($sformatf("v%0d_outstanding", i), outst_viol, 0);
      chk($sformatf("v%0d_stall_hold", i), stall_viol, 0);
      if (t.lat) begin
        chk($sformatf("v%0d_latency", i), first_val - first_rd, 2);
        chk($sformatf("v%0d_bubbles", i), bubbles, 0);
      end
      if (t.n == 0) chk($sformatf("v%0d_busy_seen", i), busy_seen, 0);
    end

    // Reset while the second word of a packet is on the bus.
    do_reset(0);
    exp_total = 8;
    for (int k = 0; k < 8; k++) push(32'h20 + k);
    for (int g = 0; g < 20 && got_d.size() < 1; g++) step();
    chk("mid_valid", valid_result, 1);
    chk("mid_data", result_data, 32'h21);
    rst = 1'b0;
    #1;
    chk("rst_async_valid", valid_result, 0);
    chk("rst_async_last", last, 0);
    chk("rst_async_data", result_data, 0);
    chk("rst_async_rd_en", fifo_rd_en, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_pkt", pkt_sent, 0);
    fifo_q.delete();
    fifo_empty = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_obs();
    exp_total = 4;
    for (int k = 0; k < 4; k++) push(32'h30 + k);
    repeat (30) step();
    chk("post_rst_count", got_d.size(), 4);
    for (int j = 0; j < 4 && j < got_d.size(); j++) begin
      chk($sformatf("post_rst_data%0d", j), got_d[j], 32'h30 + j);
      chk($sformatf("post_rst_last%0d", j), got_l[j], (j == 3) ? 1 : 0);
    end
    chk("post_rst_pkt", pkt_sent, 1);

    // Packet counter wrap from 65535.
    do_reset(0);
    force dut.r_pkt_sent = 16'hFFFF;
    #2;
    release dut.r_pkt_sent;
    chk("wrap_preload", pkt_sent, 16'hFFFF);
    exp_total = 4;
    for (int k = 0; k < 4; k++) push(32'h60 + k);
    repeat (30) step();
    chk("wrap_count", got_d.size(), 4);
    chk("wrap_pkt_sent", pkt_sent, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
